shift_reg_univ: RTL and testbench

Parametrised universal shift register, the next generation of the team's 4-bit shifting register. It adds configurable width, hold, rotate and arithmetic modes, and a counted burst-shift mode with a busy/done handshake. It sits between a control sequencer (drives `MODO`, `D`, `START`) and serial or parallel consumers (`Q`, `S_OUT`). Direction convention is unchanged: `DIR`=1 shifts right (toward bit 0), `DIR`=0 shifts left.

---
 rtl/shift_reg_pkg.sv | 21 ++
 rtl/shift_reg_univ_if.sv | 27 ++
 rtl/shift_burst_ctrl.sv | 78 +++++++
 rtl/shift_reg_univ.sv | 85 ++++++++
 tb/tb_shift_reg_univ.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode codes, burst FSM
// states and the logic-level constants the benches reuse.
package shift_reg_pkg;

  localparam logic [2:0] HOLD      = 3'b000;
  localparam logic [2:0] PARA_LOAD = 3'b001;
  localparam logic [2:0] SHIFT     = 3'b010;
  localparam logic [2:0] ROTATE    = 3'b011;
  localparam logic [2:0] ARITH     = 3'b100;
  localparam logic [2:0] BURST     = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } burst_state_t;

  localparam logic LOW    = 1'b0;
  localparam logic HIGH   = 1'b1;
  localparam logic ENABLE = 1'b1;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle between the sequencer (master) and the shift register (slave).
interface shift_reg_univ_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
);
  logic             ENB;
  logic             DIR;
  logic [2:0]       MODO;
  logic             S_IN;
  logic [WIDTH-1:0] D;
  logic [CNT_W-1:0] COUNT;
  logic             START;
  logic [WIDTH-1:0] Q;
  logic             S_OUT;
  logic             BUSY;
  logic             DONE;

  modport master (
    output ENB, DIR, MODO, S_IN, D, COUNT, START,
    input  Q, S_OUT, BUSY, DONE
  );

  modport slave (
    input  ENB, DIR, MODO, S_IN, D, COUNT, START,
    output Q, S_OUT, BUSY, DONE
  );
endinterface

// File: rtl/shift_burst_ctrl.sv
// Burst sequencer: counts down the requested number of shift steps and
// raises a one-cycle done pulse on completion (or immediately for a zero count).
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enb,
  input  logic             start,
  input  logic             dir,
  input  logic [CNT_W-1:0] count,
  output logic             step,
  output logic             step_dir,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  burst_state_t     state_reg, state_next;
  logic [CNT_W-1:0] rem_reg, rem_next;
  logic             dir_reg, dir_next;
  logic             done_reg, done_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
      dir_reg   <= LOW;
      done_reg  <= LOW;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      dir_reg   <= dir_next;
      done_reg  <= done_next;
    end
  end

  // done_next defaults low so the pulse clears on the next edge even with enb low
  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    dir_next   = dir_reg;
    done_next  = LOW;
    step       = LOW;
    case (state_reg)
      IDLE: begin
        if (enb && start) begin
          if (count != '0) begin
            state_next = RUN;
            rem_next   = count;
            dir_next   = dir;
          end else begin
            done_next = HIGH;
          end
        end
      end
      RUN: begin
        if (enb) begin
          step     = HIGH;
          rem_next = rem_reg - CNT_ONE;
          if (rem_reg == CNT_ONE) begin
            state_next = IDLE;
            done_next  = HIGH;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign step_dir = dir_reg;
  assign busy     = (state_reg == RUN);
  assign done     = done_reg;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register: hold/load/shift/rotate/arithmetic modes plus a
// counted burst shift driven by shift_burst_ctrl.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic           CLK,
  input  logic           RESET_N,
  shift_reg_univ_if.slave bus
);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             s_out_reg, s_out_next;
  logic [WIDTH-2:0] body_right, body_left;
  logic             burst_start, step, step_dir, busy, done;

  assign burst_start = bus.START && (bus.MODO == BURST);

  shift_burst_ctrl #(
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .enb      (bus.ENB),
    .start    (burst_start),
    .dir      (bus.DIR),
    .count    (bus.COUNT),
    .step     (step),
    .step_dir (step_dir),
    .busy     (busy),
    .done     (done)
  );

  // Shifted bodies without the vacated end bit; the fill bit is chosen per mode.
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_body
      assign body_right[gi] = q_reg[gi+1];
      assign body_left[gi]  = q_reg[gi];
    end
  endgenerate

  always_comb begin
    q_next     = q_reg;
    s_out_next = s_out_reg;
    if (step) begin
      q_next     = step_dir ? {bus.S_IN, body_right} : {body_left, bus.S_IN};
      s_out_next = step_dir ? q_reg[0] : q_reg[WIDTH-1];
    end else if (bus.ENB && !busy) begin
      case (bus.MODO)
        PARA_LOAD: q_next = bus.D;
        SHIFT: begin
          q_next     = bus.DIR ? {bus.S_IN, body_right} : {body_left, bus.S_IN};
          s_out_next = bus.DIR ? q_reg[0] : q_reg[WIDTH-1];
        end
        ROTATE: begin
          q_next     = bus.DIR ? {q_reg[0], body_right} : {body_left, q_reg[WIDTH-1]};
          s_out_next = bus.DIR ? q_reg[0] : q_reg[WIDTH-1];
        end
        ARITH: begin
          q_next     = bus.DIR ? {q_reg[WIDTH-1], body_right} : {body_left, LOW};
          s_out_next = bus.DIR ? q_reg[0] : q_reg[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      q_reg     <= '0;
      s_out_reg <= LOW;
    end else begin
      q_reg     <= q_next;
      s_out_reg <= s_out_next;
    end
  end

  assign bus.Q     = q_reg;
  assign bus.S_OUT = s_out_reg;
  assign bus.BUSY  = busy;
  assign bus.DONE  = done;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Bench for shift_reg_univ: directed WIDTH=4 and WIDTH=8 scenarios followed by
// randomized WIDTH=8 traffic checked against an arithmetic reference model.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  shift_reg_univ_if #(.WIDTH(4), .CNT_W(3)) bus4 ();
  shift_reg_univ_if #(.WIDTH(8), .CNT_W(4)) bus8 ();

  shift_reg_univ #(.WIDTH(4), .CNT_W(3)) u_dut4 (.CLK(clk), .RESET_N(rst_n), .bus(bus4));
  shift_reg_univ #(.WIDTH(8), .CNT_W(4)) u_dut8 (.CLK(clk), .RESET_N(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state for the WIDTH=8 instance
  int m_q, m_s, m_pend, m_done;
  bit m_bdir;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic enb, input logic [2:0] modo, input logic dir,
                        input logic s_in, input logic [3:0] d);
    bus4.ENB = enb; bus4.MODO = modo; bus4.DIR = dir; bus4.S_IN = s_in; bus4.D = d;
  endtask

  task automatic exp4(input string tag, input logic [3:0] q, input logic s);
    tick();
    $display("dut4 %s: Q=%b S_OUT=%b", tag, bus4.Q, bus4.S_OUT);
    chk({tag, " Q"}, 16'(bus4.Q), 16'(q));
    chk({tag, " S_OUT"}, 16'(bus4.S_OUT), 16'(s));
  endtask

  task automatic exp8(input string tag, input logic [7:0] q, input logic busy, input logic done);
    tick();
    $display("dut8 %s: Q=%h BUSY=%b DONE=%b", tag, bus8.Q, bus8.BUSY, bus8.DONE);
    chk({tag, " Q"}, 16'(bus8.Q), 16'(q));
    chk({tag, " BUSY"}, 16'(bus8.BUSY), 16'(busy));
    chk({tag, " DONE"}, 16'(bus8.DONE), 16'(done));
  endtask

  task automatic model_shift(input bit right, input int fill);
    m_s = right ? (m_q % 2) : (m_q / 128);
    m_q = right ? ((m_q / 2) + fill * 128) : (((m_q * 2) % 256) + fill);
  endtask

  task automatic model_edge();
    int nd = 0;
    if (m_pend > 0) begin
      if (bus8.ENB) begin
        model_shift(m_bdir, int'(bus8.S_IN));
        m_pend--;
        if (m_pend == 0) nd = 1;
      end
    end else if (bus8.ENB) begin
      case (bus8.MODO)
        PARA_LOAD: m_q = int'(bus8.D);
        SHIFT:     model_shift(bus8.DIR, int'(bus8.S_IN));
        ROTATE:    model_shift(bus8.DIR, bus8.DIR ? (m_q % 2) : (m_q / 128));
        ARITH:     model_shift(bus8.DIR, bus8.DIR ? (m_q / 128) : 0);
        BURST: begin
          if (bus8.START) begin
            if (bus8.COUNT == 0) nd = 1;
            else begin
              m_pend = int'(bus8.COUNT);
              m_bdir = bus8.DIR;
            end
          end
        end
        default: ;
      endcase
    end
    m_done = nd;
  endtask

  task automatic model_reset();
    m_q = 0; m_s = 0; m_pend = 0; m_done = 0; m_bdir = 0;
  endtask

  initial begin
    drive4(LOW, HOLD, LOW, LOW, 4'h0);
    bus4.COUNT = '0; bus4.START = LOW;
    bus8.ENB = LOW; bus8.MODO = HOLD; bus8.DIR = LOW; bus8.S_IN = LOW;
    bus8.D = '0; bus8.COUNT = '0; bus8.START = LOW;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    #1;
    chk("reset Q4", 16'(bus4.Q), 16'h0);
    chk("reset S_OUT4", 16'(bus4.S_OUT), 16'h0);
    chk("reset BUSY8", 16'(bus8.BUSY), 16'h0);
    chk("reset DONE8", 16'(bus8.DONE), 16'h0);

    // WIDTH=4 shift right
    drive4(ENABLE, PARA_LOAD, HIGH, LOW, 4'b1000); exp4("load 1000", 4'b1000, 1'b0);
    drive4(ENABLE, SHIFT, HIGH, LOW, 4'b0000);
    exp4("shr1", 4'b0100, 1'b0);
    exp4("shr2", 4'b0010, 1'b0);
    exp4("shr3", 4'b0001, 1'b0);
    exp4("shr4", 4'b0000, 1'b1);
    // rotate
    drive4(ENABLE, PARA_LOAD, LOW, LOW, 4'b1001); exp4("load 1001", 4'b1001, 1'b1);
    drive4(ENABLE, ROTATE, LOW, LOW, 4'b0000);    exp4("rotl", 4'b0011, 1'b1);
    drive4(ENABLE, ROTATE, HIGH, LOW, 4'b0000);   exp4("rotr1", 4'b1001, 1'b1);
    exp4("rotr2", 4'b1100, 1'b1);
    // arithmetic
    drive4(ENABLE, PARA_LOAD, HIGH, LOW, 4'b1000); exp4("load 1000b", 4'b1000, 1'b1);
    drive4(ENABLE, ARITH, HIGH, LOW, 4'b0000);
    exp4("asr1", 4'b1100, 1'b0);
    exp4("asr2", 4'b1110, 1'b0);
    drive4(ENABLE, PARA_LOAD, LOW, HIGH, 4'b0110); exp4("load 0110", 4'b0110, 1'b0);
    drive4(ENABLE, ARITH, LOW, HIGH, 4'b0000);     exp4("asl", 4'b1100, 1'b0);
    drive4(LOW, HOLD, LOW, LOW, 4'b0000);

    // WIDTH=8 burst of 3, right
    bus8.ENB = ENABLE; bus8.MODO = PARA_LOAD; bus8.D = 8'h81; exp8("load 81", 8'h81, 0, 0);
    bus8.MODO = BURST; bus8.START = HIGH; bus8.COUNT = 4'd3; bus8.DIR = HIGH; bus8.S_IN = LOW;
    exp8("burst edge0", 8'h81, 1, 0);
    bus8.START = LOW; bus8.DIR = LOW; bus8.MODO = PARA_LOAD;
    exp8("burst edge1", 8'h40, 1, 0);
    chk("burst edge1 S_OUT", 16'(bus8.S_OUT), 16'h1);
    exp8("burst edge2", 8'h20, 1, 0);
    exp8("burst edge3", 8'h10, 0, 1);
    chk("burst edge3 S_OUT", 16'(bus8.S_OUT), 16'h0);
    bus8.MODO = HOLD;
    exp8("burst edge4", 8'h10, 0, 0);

    // burst of 3 with one paused RUN cycle
    bus8.MODO = PARA_LOAD; bus8.D = 8'h81; exp8("reload 81", 8'h81, 0, 0);
    bus8.MODO = BURST; bus8.START = HIGH; bus8.DIR = HIGH;
    exp8("pburst edge0", 8'h81, 1, 0);
    bus8.START = LOW; bus8.ENB = LOW;
    exp8("pburst paused", 8'h81, 1, 0);
    bus8.ENB = ENABLE;
    exp8("pburst edge2", 8'h40, 1, 0);
    exp8("pburst edge3", 8'h20, 1, 0);
    exp8("pburst edge4", 8'h10, 0, 1);

    // zero-count burst
    bus8.START = HIGH; bus8.COUNT = 4'd0;
    exp8("zero burst", 8'h10, 0, 1);
    bus8.START = LOW;
    exp8("zero burst after", 8'h10, 0, 0);

    // asynchronous reset mid-burst
    bus8.START = HIGH; bus8.COUNT = 4'd5;
    exp8("rst burst edge0", 8'h10, 1, 0);
    bus8.START = LOW;
    exp8("rst burst edge1", 8'h08, 1, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async rst Q", 16'(bus8.Q), 16'h0);
    chk("async rst BUSY", 16'(bus8.BUSY), 16'h0);
    chk("async rst DONE", 16'(bus8.DONE), 16'h0);
    chk("async rst S_OUT", 16'(bus8.S_OUT), 16'h0);
    #1 rst_n = 1'b1;
    bus8.MODO = PARA_LOAD; bus8.D = 8'hA5;
    exp8("load after rst", 8'hA5, 0, 0);

    // randomized traffic against the model, with one asynchronous reset
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 300; i++) begin
      bus8.ENB   = ($urandom_range(0, 4) != 0);
      bus8.MODO  = ($urandom_range(0, 2) == 0) ? BURST : 3'($urandom_range(0, 7));
      bus8.DIR   = 1'($urandom_range(0, 1));
      bus8.S_IN  = 1'($urandom_range(0, 1));
      bus8.D     = 8'($urandom_range(0, 255));
      bus8.COUNT = 4'($urandom_range(0, 11));
      bus8.START = 1'($urandom_range(0, 1));
      model_edge();
      tick();
      chk("rand Q", 16'(bus8.Q), 16'(m_q));
      chk("rand S_OUT", 16'(bus8.S_OUT), 16'(m_s));
      chk("rand BUSY", 16'(bus8.BUSY), 16'(m_pend > 0));
      chk("rand DONE", 16'(bus8.DONE), 16'(m_done));
      if (i == 150) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rand rst Q", 16'(bus8.Q), 16'h0);
        chk("rand rst BUSY", 16'(bus8.BUSY), 16'h0);
        #1 rst_n = 1'b1;
      end
    end
    $display("random phase: %0d cycles", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
